// File: rtl/pc_branch_ctrl_pkg.sv
// Purpose: shared branch-control constants: funct3 codes, controller states, PC step.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: F3_* branch funct3 codes, br_state_t {S_RUN, S_FLUSH}, PC_STEP.
package riscv_br_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic {
      S_RUN   = 1'b0,
      S_FLUSH = 1'b1
   } br_state_t;

endpackage

// File: rtl/pc_branch_ctrl_if.sv
// Purpose: bundles the EX-stage branch inputs and the IF-side PC/flush outputs.
// Latency: n/a (wiring only).
// Backpressure: stall is carried as a plain level; the controller holds the PC while it is high.
// Modports: master = EX/hazard side (drives EX inputs, sees PC/flush),
//           slave  = pc_branch_ctrl (consumes EX inputs, drives cmpop/pc/redirect/flush/misalign).
interface pc_branch_ctrl_if;

   logic        stall;
   logic        ex_valid;
   logic        ex_is_branch;
   logic        ex_is_jump;
   logic [2:0]  ex_funct3;
   logic        br_eq;
   logic        br_lt;
   logic [31:0] ex_target;

   logic        cmpop;
   logic [31:0] pc;
   logic        redirect;
   logic        flush;
   logic        misalign;

   modport master (
      output stall, ex_valid, ex_is_branch, ex_is_jump, ex_funct3, br_eq, br_lt, ex_target,
      input  cmpop, pc, redirect, flush, misalign
   );

   modport slave (
      input  stall, ex_valid, ex_is_branch, ex_is_jump, ex_funct3, br_eq, br_lt, ex_target,
      output cmpop, pc, redirect, flush, misalign
   );

endinterface

// File: rtl/pc_branch_ctrl_br_decide.sv
// Purpose: decodes branch funct3 into comparator mode and taken decision from eq/lt flags.
// Latency: purely combinational.
// Backpressure: none.
// Ports: funct3[2:0], br_eq, br_lt in; taken, cmpop (1 = signed compare) out.
module br_decide
   import riscv_br_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       br_eq,
   input  logic       br_lt,
   output logic       taken,
   output logic       cmpop
);

   // funct3[1] separates the unsigned pair (BLTU/BGEU) from the signed one;
   // BEQ/BNE land on signed, which does not affect the equality flag.
   assign cmpop = ~funct3[1];

   always_comb begin
      taken = 1'b0;
      case (funct3)
         F3_BEQ:           taken = br_eq;
         F3_BNE:           taken = ~br_eq;
         F3_BLT, F3_BLTU:  taken = br_lt;
         F3_BGE, F3_BGEU:  taken = ~br_lt;
         default:          taken = 1'b0;   // 010/011 are not branches
      endcase
   end

endmodule

// File: rtl/pc_branch_ctrl.sv
// Purpose: owns the fetch PC, resolves branches/jumps from EX and flushes younger instructions.
// Latency: redirect is combinational; new PC and flush appear the cycle after; flush lasts FLUSH_DEPTH unstalled cycles.
// Backpressure: stall holds the PC and freezes the flush countdown; an accepted redirect overrides stall.
// Ports: clk, rst (async, active-high); bus (pc_branch_ctrl_if.slave) with EX inputs and
//        cmpop/pc/redirect/flush/misalign outputs.
// Optional: `define BRANCH_STATS_EN adds br_count/br_taken_count output ports.
module pc_branch_ctrl
   import riscv_br_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int unsigned FLUSH_DEPTH = 2
)(
   input  logic                 clk,
   input  logic                 rst,
   pc_branch_ctrl_if.slave      bus
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]          br_count,
   output logic [31:0]          br_taken_count
`endif
);

   localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_DEPTH);

   br_state_t   state;
   logic [2:0]  flush_cnt;
   logic [31:0] pc_q;
   logic        flush_q;
   logic        misalign_q;

   logic        br_taken;
   logic        cmpop_w;
   logic [31:0] tgt;
   logic        in_run;
   logic        take;
   logic        redirect_w;
   logic        unused_tgt_lsb;

   br_decide u_decide (
      .funct3 (bus.ex_funct3),
      .br_eq  (bus.br_eq),
      .br_lt  (bus.br_lt),
      .taken  (br_taken),
      .cmpop  (cmpop_w)
   );

   // Bit 0 of the adder result is always discarded (JALR semantics).
   assign tgt            = {bus.ex_target[31:1], 1'b0};
   assign unused_tgt_lsb = bus.ex_target[0];

   // While flushing, the EX instruction is itself being killed, so it is ignored.
   assign in_run     = (state == S_RUN);
   assign take       = bus.ex_valid & (bus.ex_is_jump | (bus.ex_is_branch & br_taken)) & in_run;
   // A target with bit 1 set is reported as misaligned instead of being followed.
   assign redirect_w = take & ~tgt[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         state      <= S_RUN;
         flush_cnt  <= 3'd0;
         flush_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= take & tgt[1];

         if (redirect_w) begin
            pc_q <= tgt;
         end else if (!bus.stall) begin
            pc_q <= pc_q + PC_STEP;
         end

         case (state)
            S_RUN: begin
               if (redirect_w) begin
                  state     <= S_FLUSH;
                  flush_cnt <= FLUSH_INIT;
                  flush_q   <= 1'b1;
               end
            end
            S_FLUSH: begin
               // Only advancing cycles consume flush slots; stalled ones keep the bubble in place.
               if (!bus.stall) begin
                  if (flush_cnt == 3'd1) begin
                     state     <= S_RUN;
                     flush_cnt <= 3'd0;
                     flush_q   <= 1'b0;
                  end else begin
                     flush_cnt <= flush_cnt - 3'd1;
                  end
               end
            end
            default: begin
               state     <= S_RUN;
               flush_cnt <= 3'd0;
               flush_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cmpop    = cmpop_w;
   assign bus.pc       = pc_q;
   assign bus.redirect = redirect_w;
   assign bus.flush    = flush_q;
   assign bus.misalign = misalign_q;

`ifdef BRANCH_STATS_EN
   logic br_seen;
   assign br_seen = bus.ex_valid & bus.ex_is_branch & in_run & ~bus.stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_count       <= 32'd0;
         br_taken_count <= 32'd0;
      end else if (br_seen) begin
         br_count <= br_count + 32'd1;
         if (br_taken) begin
            br_taken_count <= br_taken_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/pc_branch_ctrl.md
Name: pc_branch_ctrl

Overview:
- Downstream consumer of the branch comparator. Decodes branch funct3 and drives `cmpop` back to the comparator. Combines `br_eq`/`br_lt` into a taken decision and owns the fetch PC register.
- On a taken branch or jump, redirects the PC and holds a registered `flush` for FLUSH_DEPTH advancing cycles to kill younger instructions.
- Sits between the EX stage (comparator, target adder) and the IF stage (instruction memory address).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FLUSH_DEPTH, 2, number of advancing cycles `flush` stays high after a redirect (range 1..7).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  pipeline hold from hazard unit.
- ex_valid  input  1  EX-stage instruction is valid.
- ex_is_branch  input  1  EX instruction is a conditional branch.
- ex_is_jump  input  1  EX instruction is JAL or JALR.
- ex_funct3  input  3  branch funct3.
- br_eq  input  1  comparator equal flag.
- br_lt  input  1  comparator less-than flag.
- ex_target  input  32  branch/jump target from the adder.
- cmpop  output  1  comparator mode; 1 = signed, 0 = unsigned.
- pc  output  32  current fetch PC (registered).
- redirect  output  1  combinational; high in the cycle a redirect is accepted.
- flush  output  1  registered kill signal for the IF/ID stages.
- misalign  output  1  registered one-cycle pulse: taken target not 4-byte aligned.

Behaviour:
- Reset state, applied asynchronously: pc = RESET_PC, flush = 0, misalign = 0, state = S_RUN, flush counter = 0.
- cmpop is combinational: cmpop = ~ex_funct3[1].
  - BLT/BGE are signed.
  - BLTU/BGEU are unsigned.
  - BEQ/BNE produce cmpop = 1, which is harmless for them.
- Taken decode by funct3:
  - 000 taken = br_eq
  - 001 taken = ~br_eq
  - 100 / 110 taken = br_lt
  - 101 / 111 taken = ~br_lt
  - 010 / 011 taken = 0 (illegal, not taken)
- Jumps are always taken.
- Effective target: tgt = {ex_target[31:1], 1'b0}.
- take = ex_valid & (ex_is_jump | (ex_is_branch & taken)) & (state == S_RUN).
- redirect = take & ~tgt[1].
- If take & tgt[1]: misalign <= 1 for exactly one cycle, no redirect, and the PC follows the normal update.
- PC update priority, highest first:
  1. redirect: pc <= tgt, even when stall is high.
  2. stall: pc holds.
  3. otherwise: pc <= pc + 4, 32-bit wrap (32'hFFFF_FFFC -> 0).
- FSM S_RUN:
  - On redirect: go to S_FLUSH, set counter = FLUSH_DEPTH, flush <= 1 from the next cycle.
- FSM S_FLUSH:
  - flush = 1.
  - ex_valid is ignored: no redirect and no misalign.
  - Counter decrements only on cycles with stall = 0.
  - When the counter reaches 1 with stall = 0, the next state is S_RUN and flush drops on that edge.
  - The PC advances normally (+4 or hold on stall).
- Latency:
  - Redirect cycle N: pc = tgt visible at cycle N+1.
  - flush is high for cycles N+1 .. N+FLUSH_DEPTH when there is no stall.
- Simultaneous ex_is_branch and ex_is_jump: treated as a jump.
- Reset asserted mid-flush clears everything immediately. No stale flush is emitted after reset release.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined:
  - Adds output ports br_count[31:0] and br_taken_count[31:0], both reset to 0.
  - br_count increments on each cycle with ex_valid & ex_is_branch & state == S_RUN & ~stall.
  - br_taken_count increments on the subset that is taken.
  - Both wrap at 2^32.
- When undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Shared package riscv_br_pkg:
  - funct3 constants F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - state enum {S_RUN, S_FLUSH}.
  - PC_STEP = 4.
- One natural sub-module: br_decide, purely combinational. Inputs are funct3, br_eq, br_lt; outputs are taken and cmpop. It is reusable by the comparator testbench.

Test Plan:
- Reset with RESET_PC = 32'h100, then release -> pc sequence 0x100, 0x104, 0x108; flush = 0; misalign = 0.
- BEQ (funct3 000), br_eq = 1, ex_target = 0x200 at pc 0x10C -> redirect = 1 that cycle; pc = 0x200 next; flush high for exactly 2 cycles; second branch presented during flush is ignored.
- BLTU (110) -> cmpop = 0; BGE (101) with br_lt = 0 -> cmpop = 1 and taken; funct3 011 with br_eq = 1 -> not taken, pc + 4.
- JALR target 0x303 -> pc = 0x302, but bit 1 is set -> misalign pulse for 1 cycle, no redirect, pc + 4. Target 0x301 -> pc = 0x300, redirect.
- Redirect with stall = 1 -> pc takes target. Stall held 3 cycles in S_FLUSH -> flush stays high until 2 unstalled cycles have elapsed. pc at 0xFFFF_FFFC with no stall -> wraps to 0.
- Assert rst during S_FLUSH -> flush = 0 and pc = RESET_PC immediately. With BRANCH_STATS_EN: 5 branches, 3 taken -> br_count = 5, br_taken_count = 3.
